// File: rtl/ysyx_mem_arbiter.sv
// ysyx_mem_arbiter: shares one memory port between IFU and LSU, one transaction at a time,
// round-robin on ties, with a WAIT timeout that returns an error response.
module ysyx_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_resp_err,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_resp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int CW = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t              r_state, w_next;
    logic                r_owner, r_last;  // 0 = IFU, 1 = LSU
    logic [CW-1:0]       r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wen;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wmask;
    logic                r_ifu_rv, r_lsu_rv, r_err;
    logic [DATA_W-1:0]   r_rdata;
    logic                w_idle, w_gnt_ifu, w_gnt_lsu, w_resp, w_tmo;

    // Grants are gated by rst so nothing is accepted while the block is held in reset.
    assign w_idle    = r_state == S_IDLE && !rst;
    assign w_gnt_ifu = w_idle && ifu_req_valid && (!lsu_req_valid || r_last);
    assign w_gnt_lsu = w_idle && lsu_req_valid && !w_gnt_ifu;
    assign w_resp    = r_state == S_WAIT && mem_resp_valid;
    assign w_tmo     = r_state == S_WAIT && !mem_resp_valid && TIMEOUT != 0 && r_cnt == CW'(TIMEOUT - 1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = (w_gnt_ifu || w_gnt_lsu) ? S_ISSUE : S_IDLE;
            S_ISSUE: w_next = mem_req_ready ? S_WAIT : S_ISSUE;
            S_WAIT:  w_next = (w_resp || w_tmo) ? S_IDLE : S_WAIT;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner  <= 1'b0;
            r_last   <= 1'b1;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_wen    <= 1'b0;
            r_wdata  <= '0;
            r_wmask  <= '0;
            r_ifu_rv <= 1'b0;
            r_lsu_rv <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            if (w_gnt_ifu || w_gnt_lsu) begin
                r_owner <= w_gnt_lsu;
                r_last  <= w_gnt_lsu;
                r_addr  <= w_gnt_lsu ? lsu_addr : ifu_addr;
                r_wen   <= w_gnt_lsu && lsu_wen;
                r_wdata <= w_gnt_lsu ? lsu_wdata : '0;
                r_wmask <= w_gnt_lsu ? lsu_wmask : '0;
            end
            if (r_state == S_ISSUE && mem_req_ready) r_cnt <= '0;
            else if (r_state == S_WAIT && !mem_resp_valid) r_cnt <= r_cnt + 1'b1;
            // A response on the timeout cycle wins because w_tmo requires !mem_resp_valid.
            r_ifu_rv <= (w_resp || w_tmo) && !r_owner;
            r_lsu_rv <= (w_resp || w_tmo) && r_owner;
            r_err    <= w_tmo;
            r_rdata  <= w_resp ? mem_rdata : '0;
        end
    end

    assign ifu_req_ready  = w_gnt_ifu;
    assign lsu_req_ready  = w_gnt_lsu;
    assign ifu_resp_valid = r_ifu_rv;
    assign lsu_resp_valid = r_lsu_rv;
    assign ifu_resp_err   = r_ifu_rv && r_err;
    assign lsu_resp_err   = r_lsu_rv && r_err;
    assign ifu_rdata      = r_ifu_rv ? r_rdata : '0;
    assign lsu_rdata      = r_lsu_rv ? r_rdata : '0;
    assign mem_req_valid  = r_state == S_ISSUE;
    assign mem_addr       = r_addr;
    assign mem_wen        = r_wen;
    assign mem_wdata      = r_wdata;
    assign mem_wmask      = r_wmask;
endmodule

// File: tb/tb_ysyx_mem_arbiter.sv
// tb_ysyx_mem_arbiter: table vectors, hand sequences and random transactions against a
// transaction-level model of the arbiter with a configurable-latency memory.
module tb_ysyx_mem_arbiter;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid = 1'b0, ifu_req_ready;
    logic [31:0] ifu_addr = '0;
    logic        ifu_resp_valid, ifu_resp_err;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid = 1'b0, lsu_req_ready;
    logic [31:0] lsu_addr = '0;
    logic        lsu_wen = 1'b0;
    logic [31:0] lsu_wdata = '0;
    logic [3:0]  lsu_wmask = '0;
    logic        lsu_resp_valid, lsu_resp_err;
    logic [31:0] lsu_rdata;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    ysyx_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          iv, lv;
        logic [31:0] ia, la;
        bit          wen;
        logic [31:0] wd;
        logic [3:0]  wm;
        int          rdy, lat;
        logic [31:0] md;
        bit          g, err;
        logic [31:0] rd;
    } vec_t;

    int n_chk = 0, n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory: ready after m_rdy ISSUE cycles, response on WAIT cycle m_lat (0 = never).
    int          cyc = 0, hs_cyc = 0, m_rdy = 0, m_lat = 1;
    logic [31:0] m_data = '0, man_d = '0;
    bit          m_manual = 1'b1, man_v = 1'b0;

    initial begin
        int wc, rc;
        wc = -1; rc = 0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (m_manual) begin
                wc = -1; rc = 0;
                mem_req_ready = 1'b0; mem_resp_valid = man_v; mem_rdata = man_d;
            end else begin
                mem_resp_valid = 1'b0; mem_rdata = '0;
                if (mem_req_ready) begin
                    mem_req_ready = 1'b0; wc = 0; hs_cyc = cyc;
                end
                if (wc >= 0) begin
                    wc++;
                    if (wc == m_lat) begin
                        mem_resp_valid = 1'b1; mem_rdata = m_data; wc = -1;
                    end else if (wc >= TO) wc = -1;
                end
                if (mem_req_valid && wc < 0) begin
                    if (rc >= m_rdy) begin
                        mem_req_ready = 1'b1; rc = 0;
                    end else rc++;
                end
            end
        end
    end

    int          n_resp = 0, r_cyc = 0;
    bit          r_who, r_err;
    logic [31:0] r_data;

    initial forever begin
        @(negedge clk); #1;
        if (ifu_resp_valid || lsu_resp_valid) begin
            n_resp++;
            r_who  = lsu_resp_valid;
            r_data = lsu_resp_valid ? lsu_rdata : ifu_rdata;
            r_err  = lsu_resp_valid ? lsu_resp_err : ifu_resp_err;
            r_cyc  = cyc;
            check("single_resp", ifu_resp_valid & lsu_resp_valid, 0);
        end
    end

    bit          chk_fields = 1'b0, ex_wen;
    logic [31:0] ex_addr, ex_wdata;
    logic [3:0]  ex_wmask;

    initial forever begin
        @(negedge clk); #1;
        if (chk_fields && mem_req_valid) begin
            check("mem_addr", mem_addr, ex_addr);
            check("mem_wen", mem_wen, ex_wen);
            check("mem_wmask", mem_wmask, ex_wmask);
            if (ex_wen) check("mem_wdata", mem_wdata, ex_wdata);
        end
    end

    int gq[$], gc[$];
    initial forever begin
        @(negedge clk); #1;
        if (ifu_req_ready || lsu_req_ready) begin
            gq.push_back(int'(lsu_req_ready));
            gc.push_back(cyc);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check_quiet(input string name);
        check({name, "_ctrl"}, {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid,
                                ifu_resp_err, lsu_resp_err, mem_req_valid, mem_wen}, 0);
        check({name, "_data"}, ifu_rdata | lsu_rdata | mem_addr | mem_wdata | {28'b0, mem_wmask}, 0);
    endtask

    task automatic do_reset();
        m_manual = 1'b1; man_v = 1'b0;
        rst = 1'b1; ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        @(negedge clk); @(negedge clk); #2;
        check_quiet("reset");
        @(negedge clk);
        rst = 1'b0; ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; m_manual = 1'b0;
    endtask

    task automatic run_txn(input vec_t v);
        int  t, n0, eff;
        bit  g;
        m_rdy = v.rdy; m_lat = v.lat; m_data = v.md;
        @(negedge clk);
        ifu_req_valid = v.iv; ifu_addr = v.ia;
        lsu_req_valid = v.lv; lsu_addr = v.la; lsu_wen = v.wen; lsu_wdata = v.wd; lsu_wmask = v.wm;
        #2; t = 0;
        while (!(ifu_req_ready || lsu_req_ready) && t < 20) begin
            @(negedge clk); #2; t++;
        end
        check("grant_seen", t < 20, 1);
        check("one_ready", ifu_req_ready & lsu_req_ready, 0);
        g = lsu_req_ready;
        check("grant", g, v.g);
        ex_addr = g ? v.la : v.ia; ex_wen = g & v.wen; ex_wdata = v.wd; ex_wmask = g ? v.wm : 4'h0;
        chk_fields = 1'b1;
        n0 = n_resp;
        @(negedge clk);
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        #2; t = 0;
        while (n_resp == n0 && t < 40) begin
            @(negedge clk); #2; t++;
        end
        chk_fields = 1'b0;
        check("resp_seen", n_resp - n0, 1);
        check("resp_owner", r_who, v.g);
        check("resp_err", r_err, v.err);
        if (!(v.g && v.wen)) check("resp_rdata", r_data, v.rd);
        eff = (v.lat == 0 || v.lat > TO) ? TO : v.lat;
        check("resp_latency", r_cyc - hs_cyc, eff);
    endtask

    vec_t tbl[9];
    initial begin
        vec_t v;
        int   t, n0, r;
        bit   m_last;
        rst = 1'b1;
        //          iv lv ia            la            wen wd            wm    rdy lat md             g  err rd
        tbl[0] = '{1, 0, 32'h8000_0000, 32'h0,        0, 32'h0,        4'h0, 0, 2, 32'h0000_0413, 0, 0, 32'h0000_0413};
        tbl[1] = '{0, 1, 32'h0,         32'h8000_1000, 1, 32'hDEADBEEF, 4'hF, 3, 1, 32'h1234,      1, 0, 32'h0};
        tbl[2] = '{1, 1, 32'h10,        32'h20,       0, 32'h0,        4'h0, 1, 3, 32'hA5A5,      0, 0, 32'hA5A5};
        tbl[3] = '{1, 1, 32'h14,        32'h24,       0, 32'h0,        4'h0, 0, 4, 32'h55,        1, 0, 32'h55};
        tbl[4] = '{0, 1, 32'h0,         32'h8000_2000, 0, 32'h0,        4'h0, 0, 0, 32'h99,        1, 1, 32'h0};
        tbl[5] = '{1, 1, 32'h18,        32'h28,       0, 32'h0,        4'h0, 2, 5, 32'h66,        0, 1, 32'h0};
        tbl[6] = '{1, 0, 32'h1C,        32'h0,        0, 32'h0,        4'h0, 0, 1, 32'hCAFEF00D,  0, 0, 32'hCAFEF00D};
        tbl[7] = '{1, 1, 32'h30,        32'h34,       1, 32'h1111_2222, 4'h3, 1, 2, 32'h77,        1, 0, 32'h0};
        tbl[8] = '{1, 1, 32'h38,        32'h3C,       0, 32'h0,        4'h0, 0, 1, 32'h88,        0, 0, 32'h88};

        // Tie fairness straight out of reset: IFU, LSU, IFU, LSU, regranting on the pulse cycle.
        do_reset();
        m_rdy = 0; m_lat = 1; m_data = 32'h4242;
        gq.delete(); gc.delete();
        n0 = n_resp;
        @(negedge clk);
        ifu_req_valid = 1'b1; ifu_addr = 32'h100;
        lsu_req_valid = 1'b1; lsu_addr = 32'h200; lsu_wen = 1'b0;
        #2; t = 0;
        while (gq.size() < 4 && t < 60) begin
            @(negedge clk); #2; t++;
        end
        @(negedge clk);
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        repeat (6) @(negedge clk);
        #2;
        check("tie_grants", gq.size(), 4);
        for (int i = 0; i < gq.size() && i < 4; i++) check("tie_order", gq[i], i % 2);
        if (gc.size() >= 4) begin
            check("tie_regrant_gap", gc[1] - gc[0], 3);
            check("tie_regrant_gap", gc[3] - gc[2], 3);
        end
        check("tie_resps", n_resp - n0, 4);

        do_reset();
        foreach (tbl[i]) run_txn(tbl[i]);

        // Reset during WAIT: outputs clear at once, a stray late response is ignored.
        m_rdy = 0; m_lat = 0;
        @(negedge clk);
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
        #2;
        check("mid_grant", ifu_req_ready, 1);
        @(negedge clk);
        ifu_req_valid = 1'b0;
        @(negedge clk);
        m_manual = 1'b1; rst = 1'b1;
        #2;
        check_quiet("async_reset");
        n0 = n_resp;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); man_v = 1'b1; man_d = 32'hBAD;
        @(negedge clk); man_v = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        check("stray_resp", n_resp - n0, 0);
        m_manual = 1'b0;
        v = '{1, 0, 32'h8000_0000, 32'h0, 0, 32'h0, 4'h0, 0, 2, 32'h0000_0413, 0, 0, 32'h0000_0413};
        run_txn(v);

        // Random traffic against the round-robin / timeout model.
        do_reset();
        m_last = 1'b1;
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(1, 3);
            v.iv = r[0]; v.lv = r[1];
            v.ia = $urandom; v.la = $urandom; v.wen = $urandom_range(0, 1);
            v.wd = $urandom; v.wm = 4'($urandom);
            v.rdy = $urandom_range(0, 3); v.lat = $urandom_range(0, 6); v.md = $urandom;
            v.g = (v.iv && v.lv) ? !m_last : v.lv;
            m_last = v.g;
            v.err = v.lat == 0 || v.lat > TO;
            v.rd = v.err ? 32'h0 : v.md;
            run_txn(v);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
